// File: rtl/reg_dump_pkg.sv
// Shared types and sizing for the register-file dump unit.
package reg_dump_pkg;
    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam int N         = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/reg_file_dump_unit_if.sv
// Control, register-file read port and dump stream of reg_file_dump_unit.
// Checksum_o exists only when REG_DUMP_CHECKSUM_EN is defined.
interface reg_file_dump_unit_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
);
    logic                 Start_i;
    logic [ADDR_W-1:0]    First_Reg_i;
    logic [ADDR_W-1:0]    Last_Reg_i;
    logic [ADDR_W-1:0]    Read_Register_o;
    logic [N-1:0]         Read_Data_i;
    // Dump stream: a word moves on the clock edge where Dump_Valid_o and
    // Dump_Ready_i are both high; once raised, Valid stays high and
    // Index/Data stay stable until that edge.
    logic                 Dump_Valid_o;
    logic                 Dump_Ready_i;
    logic [ADDR_W-1:0]    Dump_Index_o;
    logic [N-1:0]         Dump_Data_o;
    logic                 Busy_o;
    logic                 Done_o;
    reg_dump_pkg::state_t dbg_state;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [N-1:0]         Checksum_o;
`endif

    modport slave (
        input  Start_i, First_Reg_i, Last_Reg_i, Read_Data_i, Dump_Ready_i,
        output Read_Register_o, Dump_Valid_o, Dump_Index_o, Dump_Data_o,
`ifdef REG_DUMP_CHECKSUM_EN
        output Checksum_o,
`endif
        output Busy_o, Done_o, dbg_state
    );

    modport master (
        output Start_i, First_Reg_i, Last_Reg_i, Read_Data_i, Dump_Ready_i,
        input  Read_Register_o, Dump_Valid_o, Dump_Index_o, Dump_Data_o,
`ifdef REG_DUMP_CHECKSUM_EN
        input  Checksum_o,
`endif
        input  Busy_o, Done_o, dbg_state
    );
endinterface

// File: rtl/reg_dump_index_counter.sv
// Register index walker: loads first/last, increments modulo 2^ADDR_W,
// and flags when the current index equals the latched last index.
module reg_dump_index_counter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] cur,
    output logic              is_last
);
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] last_q;

    // Natural overflow of the index gives the 31 -> 0 wrap for ranges with first > last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_q  <= '0;
            last_q <= '0;
        end else if (load) begin
            cur_q  <= first;
            last_q <= last;
        end else if (inc) begin
            cur_q  <= cur_q + ADDR_W'(1);
        end
    end

    assign cur     = cur_q;
    assign is_last = (cur_q == last_q);
endmodule

// File: rtl/reg_file_dump_unit.sv
// Debug reader: walks a register index range and streams (index, word) pairs.
// Define REG_DUMP_CHECKSUM_EN to add a running Checksum_o over the sent words.
module reg_file_dump_unit
    import reg_dump_pkg::*;
#(
    parameter int N         = reg_dump_pkg::N,
    parameter int ADDR_W    = reg_dump_pkg::ADDR_W,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_file_dump_unit_if.slave  bus
);
    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur;
    logic              is_last;
    logic              load;
    logic              inc;
    logic              skip_cur;
    logic [N-1:0]      data_q;
    logic [ADDR_W-1:0] index_q;

    assign skip_cur = SKIP_ZERO && (cur == '0);

    reg_dump_index_counter #(.ADDR_W(ADDR_W)) u_index (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .inc     (inc),
        .first   (bus.First_Reg_i),
        .last    (bus.Last_Reg_i),
        .cur     (cur),
        .is_last (is_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.Start_i) state_nxt = READ;
            // x0 with SKIP_ZERO spends one READ cycle only to advance the index.
            READ: begin
                if (skip_cur) state_nxt = is_last ? DONE : READ;
                else          state_nxt = SEND;
            end
            SEND: if (bus.Dump_Ready_i) state_nxt = is_last ? DONE : READ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load                = 1'b0;
        inc                 = 1'b0;
        bus.Read_Register_o = '0;
        bus.Dump_Valid_o    = 1'b0;
        bus.Done_o          = 1'b0;
        bus.Busy_o          = (state != IDLE);
        case (state)
            IDLE: load = bus.Start_i;
            READ: begin
                bus.Read_Register_o = cur;
                inc                 = skip_cur && !is_last;
            end
            SEND: begin
                bus.Dump_Valid_o = 1'b1;
                inc              = bus.Dump_Ready_i && !is_last;
            end
            DONE: bus.Done_o = 1'b1;
            default: ;
        endcase
    end

    // Read data is sampled at the READ edge, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            index_q <= '0;
        end else if (state == READ && !skip_cur) begin
            data_q  <= bus.Read_Data_i;
            index_q <= cur;
        end
    end

    assign bus.Dump_Data_o  = data_q;
    assign bus.Dump_Index_o = index_q;
    assign bus.dbg_state    = state;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [N-1:0] checksum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else if (load) begin
            checksum_q <= '0;
        end else if (state == SEND && bus.Dump_Ready_i) begin
            checksum_q <= checksum_q + data_q;
        end
    end

    assign bus.Checksum_o = checksum_q;
`endif
endmodule

// File: tb/tb_reg_file_dump_unit.sv
// Bench for reg_file_dump_unit: a SKIP_ZERO=0 and a SKIP_ZERO=1 instance share stimulus;
// a negedge monitor checks every accepted word against per-instance expected queues.
module tb_reg_file_dump_unit;
  localparam int N = 32;
  localparam int AW = 5;
  localparam int W = AW + N;

  logic clk;
  logic rst_n;
  logic [N-1:0] rf [32];

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_cmp = 0;
  int n_err = 0;
  int done0 = 0;
  int done1 = 0;
  int exp_done0 = 0;
  int exp_done1 = 0;

  reg_file_dump_unit_if #(.N(N), .ADDR_W(AW)) if0 ();
  reg_file_dump_unit_if #(.N(N), .ADDR_W(AW)) if1 ();

  assign if0.Read_Data_i = rf[if0.Read_Register_o];
  assign if1.Read_Data_i = rf[if1.Read_Register_o];

  reg_file_dump_unit #(.N(N), .ADDR_W(AW), .SKIP_ZERO(1'b0)) dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if0)
  );

  reg_file_dump_unit #(.N(N), .ADDR_W(AW), .SKIP_ZERO(1'b1)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_ready(input logic r);
    if0.Dump_Ready_i = r;
    if1.Dump_Ready_i = r;
  endtask

  task automatic drive_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    @(posedge clk); #1;
    if0.Start_i = 1'b1; if0.First_Reg_i = f; if0.Last_Reg_i = l;
    if1.Start_i = 1'b1; if1.First_Reg_i = f; if1.Last_Reg_i = l;
    @(posedge clk); #1;
    if0.Start_i = 1'b0;
    if1.Start_i = 1'b0;
  endtask

  task automatic push0(input logic [AW-1:0] idx, input logic [N-1:0] d);
    exp_q0.push_back({idx, d});
  endtask

  task automatic push1(input logic [AW-1:0] idx, input logic [N-1:0] d);
    exp_q1.push_back({idx, d});
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while ((if0.Busy_o || if1.Busy_o) && cyc < 200);
    if (if0.Busy_o || if1.Busy_o) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, cyc);
    end
    chk({name, "_done0"}, 64'(done0), 64'(exp_done0));
    chk({name, "_done1"}, 64'(done1), 64'(exp_done1));
    chk({name, "_q0_left"}, 64'(exp_q0.size()), 64'd0);
    chk({name, "_q1_left"}, 64'(exp_q1.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (if0.Dump_Valid_o && if0.Dump_Ready_i) begin
      if (exp_q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut0_word: got idx %0d data 0x%0h, expected no transfer", if0.Dump_Index_o, if0.Dump_Data_o);
      end else begin
        chk("dut0_word", 64'({if0.Dump_Index_o, if0.Dump_Data_o}), 64'(exp_q0.pop_front()));
      end
    end
    if (if1.Dump_Valid_o && if1.Dump_Ready_i) begin
      if (exp_q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut1_word: got idx %0d data 0x%0h, expected no transfer", if1.Dump_Index_o, if1.Dump_Data_o);
      end else begin
        chk("dut1_word", 64'({if1.Dump_Index_o, if1.Dump_Data_o}), 64'(exp_q1.pop_front()));
      end
    end
    if (if0.Done_o) done0++;
    if (if1.Done_o) done1++;
  end

  initial begin
    int cyc;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 1'b0;
    if0.Start_i = 1'b0; if0.First_Reg_i = '0; if0.Last_Reg_i = '0;
    if1.Start_i = 1'b0; if1.First_Reg_i = '0; if1.Last_Reg_i = '0;
    set_ready(1'b0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(if0.Dump_Valid_o), 64'd0);
    chk("rst_busy", 64'(if0.Busy_o), 64'd0);
    chk("rst_done", 64'(if0.Done_o), 64'd0);
    chk("rst_index", 64'(if0.Dump_Index_o), 64'd0);
    chk("rst_data", 64'(if0.Dump_Data_o), 64'd0);
    chk("rst_raddr", 64'(if0.Read_Register_o), 64'd0);
    chk("rst_state", 64'(if0.dbg_state), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: two words, latency
    rf[5] = 32'hDEAD_BEEF;
    rf[6] = 32'h1234_5678;
    set_ready(1'b1);
    push0(5'd5, 32'hDEAD_BEEF); push0(5'd6, 32'h1234_5678);
    push1(5'd5, 32'hDEAD_BEEF); push1(5'd6, 32'h1234_5678);
    drive_start(5'd5, 5'd6);
    chk("t1_valid_cycle1", 64'(if0.Dump_Valid_o), 64'd0);
    chk("t1_raddr_read", 64'(if0.Read_Register_o), 64'd5);
    @(posedge clk); #1;
    chk("t1_valid_cycle2", 64'(if0.Dump_Valid_o), 64'd1);
    chk("t1_index_first", 64'(if0.Dump_Index_o), 64'd5);
    exp_done0++; exp_done1++;
    wait_idle("t1");

    // 2: wrapping range 30..1
    rf[30] = 32'd30; rf[31] = 32'd31; rf[1] = 32'd1;
    push0(5'd30, 32'd30); push0(5'd31, 32'd31); push0(5'd0, 32'd0); push0(5'd1, 32'd1);
    push1(5'd30, 32'd30); push1(5'd31, 32'd31); push1(5'd1, 32'd1);
    drive_start(5'd30, 5'd1);
    exp_done0++; exp_done1++;
    wait_idle("t2");

    // 3: back-pressure, output held stable
    rf[10] = 32'hA5A5_0010;
    set_ready(1'b0);
    push0(5'd10, 32'hA5A5_0010);
    push1(5'd10, 32'hA5A5_0010);
    drive_start(5'd10, 5'd10);
    cyc = 0;
    while (!if0.Dump_Valid_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    rf[10] = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 64'(if0.Dump_Valid_o), 64'd1);
      chk("t3_hold_index", 64'(if0.Dump_Index_o), 64'd10);
      chk("t3_hold_data", 64'(if0.Dump_Data_o), 64'hA5A5_0010);
      @(posedge clk); #1;
    end
    set_ready(1'b1);
    exp_done0++; exp_done1++;
    wait_idle("t3");

    // 4: zero index, with and without SKIP_ZERO
    rf[31] = 32'h3131_0031; rf[1] = 32'h0000_0101;
    push0(5'd31, 32'h3131_0031); push0(5'd0, 32'd0); push0(5'd1, 32'h0000_0101);
    push1(5'd31, 32'h3131_0031); push1(5'd1, 32'h0000_0101);
    drive_start(5'd31, 5'd1);
    exp_done0++; exp_done1++;
    wait_idle("t4a");
    push0(5'd0, 32'd0);
    drive_start(5'd0, 5'd0);
    exp_done0++; exp_done1++;
    wait_idle("t4b");

    // 5: reset during third of eight words, then a fresh dump
    for (int i = 8; i < 16; i++) rf[i] = 32'h5500_0000 | 32'(i);
    push0(5'd8, 32'h5500_0008); push0(5'd9, 32'h5500_0009);
    push1(5'd8, 32'h5500_0008); push1(5'd9, 32'h5500_0009);
    drive_start(5'd8, 5'd15);
    cyc = 0;
    while (!(if0.Dump_Valid_o && if0.Dump_Index_o == 5'd10) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_reached_word3", 64'(if0.Dump_Index_o), 64'd10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_abort_valid", 64'(if0.Dump_Valid_o), 64'd0);
    chk("t5_abort_busy", 64'(if0.Busy_o), 64'd0);
    chk("t5_abort_busy1", 64'(if1.Busy_o), 64'd0);
    chk("t5_abort_index", 64'(if0.Dump_Index_o), 64'd0);
    chk("t5_abort_data", 64'(if0.Dump_Data_o), 64'd0);
    chk("t5_abort_state", 64'(if0.dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_no_done0", 64'(done0), 64'(exp_done0));
    chk("t5_no_done1", 64'(done1), 64'(exp_done1));
    rf[1] = 32'h0000_0111; rf[2] = 32'h0000_0222;
    push0(5'd1, 32'h0000_0111); push0(5'd2, 32'h0000_0222);
    push1(5'd1, 32'h0000_0111); push1(5'd2, 32'h0000_0222);
    drive_start(5'd1, 5'd2);
    exp_done0++; exp_done1++;
    wait_idle("t5");

`ifdef REG_DUMP_CHECKSUM_EN
    // 6: checksum wraps modulo 2^32
    rf[1] = 32'd1; rf[2] = 32'd2; rf[3] = 32'hFFFF_FFFF;
    push0(5'd1, 32'd1); push0(5'd2, 32'd2); push0(5'd3, 32'hFFFF_FFFF);
    push1(5'd1, 32'd1); push1(5'd2, 32'd2); push1(5'd3, 32'hFFFF_FFFF);
    drive_start(5'd1, 5'd3);
    exp_done0++; exp_done1++;
    wait_idle("t6");
    chk("t6_checksum0", 64'(if0.Checksum_o), 64'h0000_0002);
    chk("t6_checksum1", 64'(if1.Checksum_o), 64'h0000_0002);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
